ws2812_frame_arbiter: RTL and testbench

Shares one ws2812_chain serializer between NUM_REQ independent frame sources, for example the animation engine and a rotary-menu overlay.
- Arbitrates round-robin and snapshots the winner's frame into a holding register.
- Sequences the chain's start/done handshake.
- Enforces the WS2812 latch (reset-low) gap between frames.
- Runs a watchdog against a hung chain.
- Sits between the pattern generators and ws2812_chain; it is the chain's only driver.

---
 rtl/ws2812_pkg.sv | 18 +
 rtl/ws2812_rr_pick.sv | 34 +++
 rtl/ws2812_frame_arbiter.sv | 125 ++++++++++++
 tb/tb_ws2812_frame_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants and state encoding for the WS2812 frame arbiter and its helpers.
package ws2812_pkg;

  localparam int PIX_W  = 24;
  localparam int CLK_HZ = 125_000_000;

  // 300 us reset-low latch gap and 16 ms chain watchdog at CLK_HZ
  localparam int DEF_LATCH_CYCLES   = (CLK_HZ / 1_000_000) * 300;
  localparam int DEF_TIMEOUT_CYCLES = (CLK_HZ / 1_000) * 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/ws2812_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module ws2812_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] req_rot;
  int                 j;

  always_comb begin
    onehot  = '0;
    idx     = '0;
    any     = 1'b0;
    req_rot = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      req_rot = req >> j;
      if (!any && req_rot[0]) begin
        any    = 1'b1;
        idx    = IDX_W'(j);
        onehot = NUM_REQ'(1) << j;
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Round-robin arbiter that snapshots one requester's frame and drives a shared ws2812_chain,
// enforcing the latch gap after every frame and a watchdog against a chain that never finishes.
module ws2812_frame_arbiter
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS       = 16,
  parameter int NUM_REQ        = 2,
  parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*NUM_LEDS*24-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            frame_ack,
  output logic                          chain_start,
  output logic [NUM_LEDS*24-1:0]        chain_led_data,
  input  logic                          chain_done,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int FRAME_W = NUM_LEDS * PIX_W;
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [31:0]        cnt;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               timeout_hit;
  logic               send_end;
  logic               latch_end;
  logic [FRAME_W-1:0] frames [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_frames
      assign frames[gi] = req_data[gi*FRAME_W +: FRAME_W];
    end
  endgenerate

  ws2812_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    timeout_hit = (state == SEND) && (cnt == 32'(TIMEOUT_CYCLES - 1));
    send_end    = (state == SEND) && (chain_done || timeout_hit);
    latch_end   = (state == LATCH) && (cnt == 32'(LATCH_CYCLES - 1));
    case (state)
      IDLE:    if (pick_any) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (send_end) state_next = LATCH;
      LATCH:   if (latch_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt            <= '0;
      frame_ack      <= '0;
      chain_start    <= 1'b0;
      chain_led_data <= '0;
      timeout_err    <= 1'b0;
      rr_ptr         <= '0;
      win_idx        <= '0;
      cnt            <= '0;
    end else begin
      frame_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt     <= pick_onehot;
            win_idx <= pick_idx;
          end
        end
        LOAD: begin
          chain_led_data <= frames[win_idx];
          chain_start    <= 1'b1;
          cnt            <= '0;
        end
        SEND: begin
          if (send_end) begin
            chain_start <= 1'b0;
            frame_ack   <= gnt;
            gnt         <= '0;
            rr_ptr      <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            cnt         <= '0;
            // a real completion in the watchdog's last cycle still counts as success
            if (timeout_hit && !chain_done) timeout_err <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 32'd1;
          end
        end
        LATCH: begin
          if (latch_end)      cnt <= '0;
          else if (cnt != '1) cnt <= cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// Scoreboard bench for ws2812_frame_arbiter with a behavioural chain that finishes 20 cycles after start.
module tb_ws2812_frame_arbiter;

  localparam int NL = 4;
  localparam int NR = 2;
  localparam int LC = 8;
  localparam int TC = 50;
  localparam int FW = NL * 24;
  localparam logic [FW-1:0] DATA0 = {4{24'h00FF00}};
  localparam logic [FW-1:0] DATA1 = {4{24'hA5015A}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*FW-1:0] req_data = '0;
  logic [NR-1:0] gnt;
  logic [NR-1:0] frame_ack;
  logic          chain_start;
  logic [FW-1:0] chain_led_data;
  logic          chain_done;
  logic          busy;
  logic          timeout_err;

  logic model_done = 1'b0;
  logic man_done   = 1'b0;
  logic hang       = 1'b0;
  int   model_cnt  = 0;

  typedef struct {
    logic [NR-1:0] ack;
    logic [FW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  assign chain_done = model_done | man_done;

  ws2812_frame_arbiter #(
    .NUM_LEDS       (NL),
    .NUM_REQ        (NR),
    .LATCH_CYCLES   (LC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .frame_ack      (frame_ack),
    .chain_start    (chain_start),
    .chain_led_data (chain_led_data),
    .chain_done     (chain_done),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // chain model: one-cycle done pulse on the 20th cycle of chain_start
  always @(posedge clk) begin
    #2;
    if (chain_start && !hang) begin
      model_cnt  = model_cnt + 1;
      model_done = (model_cnt == 20);
    end else begin
      model_cnt  = 0;
      model_done = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(output logic [NR-1:0] a, output int gap);
    int last_done;
    last_done = -1000;
    a   = '0;
    gap = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_ack != '0) begin
        a   = frame_ack;
        gap = i - last_done;
        $display("frame ack=%b data=%h timeout_err=%b", frame_ack, chain_led_data, timeout_err);
        return;
      end
      if (chain_done && chain_start) last_done = i;
    end
  endtask

  task automatic wait_gnt(output int n, output logic start_seen);
    n = -1;
    start_seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (chain_start) start_seen = 1'b1;
      if (gnt != '0) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    n_cmp++; n_fail++;
    $display("FAIL wait_idle: busy=%b required=0 within 300 cycles", busy);
  endtask

  task automatic pop_check(input string name, input logic [NR-1:0] a);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: ack=%b with empty scoreboard", name, a);
      return;
    end
    e = sb.pop_front();
    if (a !== e.ack) begin
      n_fail++;
      $display("FAIL %s_ack: got %b required %b", name, a, e.ack);
    end
    n_cmp++;
    if (chain_led_data !== e.data) begin
      n_fail++;
      $display("FAIL %s_data: got %h required %h", name, chain_led_data, e.data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt !== '0) begin n_fail++; $display("FAIL rst_gnt: got %b required 0", gnt); end
    n_cmp++; if (frame_ack !== '0) begin n_fail++; $display("FAIL rst_ack: got %b required 0", frame_ack); end
    n_cmp++; if (chain_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b required 0", chain_start); end
    n_cmp++; if (chain_led_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h required 0", chain_led_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_terr: got %b required 0", timeout_err); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [NR-1:0] a;
    int gap, n;
    req_data = {DATA1, DATA0};
    @(negedge clk);
    req = 2'b01;
    sb.push_back('{2'b01, DATA0});
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b required 01", gnt); end
    n_cmp++; if (chain_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b required 0", chain_start); end
    @(negedge clk);
    n_cmp++; if (chain_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b required 1", chain_start); end
    n_cmp++; if (chain_led_data !== DATA0) begin n_fail++; $display("FAIL single_snap: got %h required %h", chain_led_data, DATA0); end
    wait_ack(a, gap);
    req = '0;
    pop_check("single", a);
    n_cmp++; if (gap !== 1) begin n_fail++; $display("FAIL single_ack_lat: got %0d required 1", gap); end
    n_cmp++; if (chain_start !== 1'b0) begin n_fail++; $display("FAIL single_start_drop: got %b required 0", chain_start); end
    @(negedge clk);
    n_cmp++; if (frame_ack !== '0) begin n_fail++; $display("FAIL single_ack_pulse: got %b required 0", frame_ack); end
    n = 1;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== LC) begin n_fail++; $display("FAIL single_latch: busy low after %0d required %0d", n, LC); end
  endtask

  task automatic test_alternate();
    logic [NR-1:0] a;
    logic st;
    int gap, n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_data = {DATA1, DATA0};
    for (int f = 0; f < 4; f++) sb.push_back('{(f % 2 == 0) ? 2'b01 : 2'b10, (f % 2 == 0) ? DATA0 : DATA1});
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_gnt(n, st);
      if (f > 0) begin
        n_cmp++; if (n !== LC + 1) begin n_fail++; $display("FAIL gap_%0d: ack->gnt %0d required %0d", f, n, LC + 1); end
        n_cmp++; if (st !== 1'b0) begin n_fail++; $display("FAIL gap_start_%0d: got %b required 0", f, st); end
      end else begin
        n_cmp++; if (n < 0) begin n_fail++; $display("FAIL alt_gnt_wait: no grant got %0d required >0", n); end
      end
      n_cmp++;
      if (sb.size() == 0 || gnt !== sb[0].ack) begin
        n_fail++;
        $display("FAIL alt_gnt_%0d: got %b required %b", f, gnt, (sb.size() == 0) ? 2'b00 : sb[0].ack);
      end
      @(negedge clk);
      req_data = ~{DATA1, DATA0};
      wait_ack(a, gap);
      req_data = {DATA1, DATA0};
      if (f == 3) req = '0;
      pop_check("alt", a);
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    logic [NR-1:0] a;
    logic st;
    int gap, n;
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_pre: got %b required 0", timeout_err); end
    hang = 1'b1;
    req  = 2'b01;
    sb.push_back('{2'b01, DATA0});
    wait_gnt(n, st);
    @(negedge clk);
    n = 0;
    while (chain_start && n < 200) begin
      n++;
      @(negedge clk);
    end
    req = '0;
    n_cmp++; if (n !== TC) begin n_fail++; $display("FAIL to_len: start held %0d required %0d", n, TC); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b required 1", timeout_err); end
    $display("frame ack=%b data=%h timeout_err=%b", frame_ack, chain_led_data, timeout_err);
    pop_check("to", frame_ack);
    hang = 1'b0;
    wait_idle();
    req = 2'b10;
    sb.push_back('{2'b10, DATA1});
    wait_ack(a, gap);
    req = '0;
    pop_check("to_good", a);
    n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
    wait_idle();
  endtask

  task automatic test_async_reset();
    logic [NR-1:0] a;
    logic st;
    int gap, n;
    req = 2'b01;
    sb.push_back('{2'b01, DATA0});
    wait_ack(a, gap);
    req = '0;
    pop_check("ar_pre", a);
    wait_idle();
    req = 2'b10;
    wait_gnt(n, st);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (gnt !== '0) begin n_fail++; $display("FAIL ar_gnt: got %b required 0", gnt); end
    n_cmp++; if (chain_start !== 1'b0) begin n_fail++; $display("FAIL ar_start: got %b required 0", chain_start); end
    n_cmp++; if (chain_led_data !== '0) begin n_fail++; $display("FAIL ar_data: got %h required 0", chain_led_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b required 0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL ar_terr: got %b required 0", timeout_err); end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    sb.push_back('{2'b01, DATA0});
    wait_gnt(n, st);
    n_cmp++; if (n !== 1 || gnt !== 2'b01) begin n_fail++; $display("FAIL ar_ptr: gnt %b after %0d required 01 after 1", gnt, n); end
    wait_ack(a, gap);
    req = '0;
    pop_check("ar_post", a);
    wait_idle();
  endtask

  task automatic test_spurious_done();
    logic [NR-1:0] a;
    int gap, n;
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    n_cmp++; if (busy !== 1'b0 || gnt !== '0) begin n_fail++; $display("FAIL sp_idle: busy=%b gnt=%b required 0/00", busy, gnt); end
    @(negedge clk);
    n_cmp++; if (frame_ack !== '0) begin n_fail++; $display("FAIL sp_idle_ack: got %b required 0", frame_ack); end
    req = 2'b01;
    sb.push_back('{2'b01, DATA0});
    wait_ack(a, gap);
    req = '0;
    pop_check("sp", a);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    n_cmp++; if (frame_ack !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL sp_latch: ack=%b busy=%b required 00/1", frame_ack, busy); end
    n = 2;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== LC) begin n_fail++; $display("FAIL sp_latch_len: busy low after %0d required %0d", n, LC); end
  endtask

  task automatic test_coincident();
    logic st;
    int n;
    wait_idle();
    hang = 1'b1;
    req  = 2'b01;
    sb.push_back('{2'b01, DATA0});
    wait_gnt(n, st);
    @(negedge clk);
    repeat (TC - 1) @(negedge clk);
    n_cmp++; if (chain_start !== 1'b1) begin n_fail++; $display("FAIL co_insend: got %b required 1", chain_start); end
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    req = '0;
    $display("frame ack=%b data=%h timeout_err=%b", frame_ack, chain_led_data, timeout_err);
    pop_check("co", frame_ack);
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL co_terr: got %b required 0", timeout_err); end
    hang = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_async_reset();
    test_spurious_done();
    test_coincident();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
